rank_chime: RTL and testbench

Audio back-end for the leaderboard: consumes the leaderboard's three rank-change sound signals and plays a short multi-note chime on the board's mono PWM audio pin. Each rank (1st/2nd/3rd) has its own melody. Events from the leaderboard are level changes, not pulses, so this block detects transitions itself. It sits between the leaderboard and the top-level audio pins (audio_out, audio_sd).

---
 rtl/rank_chime_pkg.sv | 74 +++++++
 rtl/rank_chime_tone_gen.sv | 56 +++++
 rtl/rank_chime.sv | 162 ++++++++++++++++
 tb/tb_rank_chime.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rank_chime_pkg.sv
// rtl/rank_chime_pkg.sv - note frequencies, FSM states and melody tables for rank_chime
package rank_chime_pkg;

  localparam int F_C5 = 523;
  localparam int F_E5 = 659;
  localparam int F_G5 = 784;
  localparam int F_C6 = 1047;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TONE,
    ST_GAP,
    ST_NEXT
  } state_e;

  typedef enum logic [1:0] {
    NOTE_C5,
    NOTE_E5,
    NOTE_G5,
    NOTE_C6
  } note_e;

  function automatic int note_freq(input note_e note);
    case (note)
      NOTE_C5: return F_C5;
      NOTE_E5: return F_E5;
      NOTE_G5: return F_G5;
      default: return F_C6;
    endcase
  endfunction

  function automatic logic [2:0] note_count(input logic [1:0] id);
    case (id)
      2'd1:    return 3'd4;
      2'd2:    return 3'd3;
      2'd3:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Melody table indexed by {chime, note index}
  function automatic note_e note_of(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b01_00: return NOTE_C5;
      4'b01_01: return NOTE_E5;
      4'b01_10: return NOTE_G5;
      4'b01_11: return NOTE_C6;
      4'b10_00: return NOTE_E5;
      4'b10_01: return NOTE_G5;
      4'b10_10: return NOTE_C6;
      4'b11_00: return NOTE_G5;
      4'b11_01: return NOTE_C6;
      default:  return NOTE_C5;
    endcase
  endfunction

  // Bit 0 is rank 1, which has the highest priority
  function automatic logic [1:0] pick_chime(input logic [2:0] mask);
    if (mask[0]) return 2'd1;
    if (mask[1]) return 2'd2;
    if (mask[2]) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [2:0] chime_mask(input logic [1:0] id);
    case (id)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rank_chime_tone_gen.sv
// rtl/rank_chime_tone_gen.sv - square-wave tone generator, restarts low on enable rise or pitch change
module tone_gen #(
  parameter int HALF_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [HALF_W-1:0] half_i,
  output logic              wave_o
);

  logic              en_q;
  logic [HALF_W-1:0] half_q;
  logic [HALF_W-1:0] cnt_q;
  logic [HALF_W-1:0] cnt_d;
  logic              wave_q;
  logic              wave_d;
  logic              restart;

  assign restart = !en_q || (half_i != half_q);

  // The restart cycle counts as the first cycle of the half period
  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (!en_i) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (restart) begin
      cnt_d  = HALF_W'(1);
      wave_d = 1'b0;
    end else if (cnt_q == half_i - 1'b1) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      half_q <= '0;
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      en_q   <= en_i;
      half_q <= half_i;
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave_o = wave_q & en_i;

endmodule

// File: rtl/rank_chime.sv
// rtl/rank_chime.sv - plays a per-rank chime on rank-change level transitions
// Optional RANK_CHIME_QUEUE_EN: remember events that arrive while busy and replay them.
module rank_chime
  import rank_chime_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int NOTE_MS = 100,
  parameter int GAP_MS  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal_sound_1,
  input  logic       signal_sound_2,
  input  logic       signal_sound_3,
  output logic       audio_out,
  output logic       audio_sd,
  output logic       busy,
  output logic [1:0] chime_id
);

  localparam int NOTE_CYC = CLK_HZ / 1000 * NOTE_MS;
  localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
  localparam int CNT_MAX  = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int HALF_C5  = CLK_HZ / (2 * note_freq(NOTE_C5));
  localparam int HALF_E5  = CLK_HZ / (2 * note_freq(NOTE_E5));
  localparam int HALF_G5  = CLK_HZ / (2 * note_freq(NOTE_G5));
  localparam int HALF_C6  = CLK_HZ / (2 * note_freq(NOTE_C6));
  localparam int HALF_W   = $clog2(HALF_C5 + 1);

  logic [2:0]        sound;
  logic [2:0]        prev_q;
  logic [2:0]        ev;
  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [1:0]        idx_q;
  logic [1:0]        idx_d;
  logic [1:0]        chime_q;
  logic [1:0]        chime_d;
  logic [1:0]        start_sel;
  logic              start;
  logic [HALF_W-1:0] half;
  logic              tone_en;
  logic              wave;
`ifdef RANK_CHIME_QUEUE_EN
  logic [2:0]        pend_q;
  logic [2:0]        pend_d;
  logic [2:0]        pend_set;
`endif

  assign sound = {signal_sound_3, signal_sound_2, signal_sound_1};
  assign ev    = sound ^ prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    chime_d = chime_q;
    start   = 1'b0;
`ifdef RANK_CHIME_QUEUE_EN
    pend_set  = pend_q | ev;
    pend_d    = pend_set;
    start_sel = pick_chime(pend_set);
`else
    start_sel = pick_chime(ev);
`endif
    case (state_q)
      ST_IDLE: start = (start_sel != 2'd0);
      ST_TONE: begin
        if (cnt_q == CNT_W'(NOTE_CYC - 1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d = '0;
          if ({1'b0, idx_q} == note_count(chime_q) - 3'd1) begin
            state_d = ST_NEXT;
          end else begin
            state_d = ST_TONE;
            idx_d   = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_NEXT: begin
`ifdef RANK_CHIME_QUEUE_EN
        start = (start_sel != 2'd0);
`endif
        if (!start) begin
          state_d = ST_IDLE;
          chime_d = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_TONE;
      cnt_d   = '0;
      idx_d   = 2'd0;
      chime_d = start_sel;
`ifdef RANK_CHIME_QUEUE_EN
      pend_d  = pend_set & ~chime_mask(start_sel);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= sound;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      chime_q <= 2'd0;
`ifdef RANK_CHIME_QUEUE_EN
      pend_q  <= 3'b000;
`endif
    end else begin
      prev_q  <= sound;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      chime_q <= chime_d;
`ifdef RANK_CHIME_QUEUE_EN
      pend_q  <= pend_d;
`endif
    end
  end

  always_comb begin
    case (note_of(chime_q, idx_q))
      NOTE_C5: half = HALF_W'(HALF_C5);
      NOTE_E5: half = HALF_W'(HALF_E5);
      NOTE_G5: half = HALF_W'(HALF_G5);
      default: half = HALF_W'(HALF_C6);
    endcase
  end

  assign tone_en = (state_q == ST_TONE);

  tone_gen #(
    .HALF_W(HALF_W)
  ) u_tone_gen (
    .clk   (clk),
    .rst   (rst),
    .en_i  (tone_en),
    .half_i(half),
    .wave_o(wave)
  );

  assign audio_out = wave;
  assign busy      = (state_q != ST_IDLE);
  assign audio_sd  = busy;
  assign chime_id  = chime_q;

endmodule

// File: tb/tb_rank_chime.sv
// tb/tb_rank_chime.sv - randomized and directed bench for rank_chime against a timeline model
module tb_rank_chime;

  localparam int CLK_HZ = 100_000;
  localparam int NOTE   = 1000;
  localparam int GAP    = 200;
  localparam int SLOT   = NOTE + GAP;
`ifdef RANK_CHIME_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       signal_sound_1;
  logic       signal_sound_2;
  logic       signal_sound_3;
  logic       audio_out;
  logic       audio_sd;
  logic       busy;
  logic [1:0] chime_id;

  rank_chime #(
    .CLK_HZ (CLK_HZ),
    .NOTE_MS(10),
    .GAP_MS (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .signal_sound_1(signal_sound_1),
    .signal_sound_2(signal_sound_2),
    .signal_sound_3(signal_sound_3),
    .audio_out     (audio_out),
    .audio_sd      (audio_sd),
    .busy          (busy),
    .chime_id      (chime_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: active chime, cycles elapsed since it started, pending ranks
  int         m_act = 0;
  int         m_t   = 0;
  logic [3:1] m_pend = '0;
  logic [3:1] m_prev = '0;
  logic [3:1] cur;
  int         run = 0;
  int         last_run = 0;

  function automatic int n_notes(input int id);
    return 5 - id;
  endfunction

  function automatic int half_of(input int id, input int idx);
    int f;
    case (id - 1 + idx)
      0:       f = 523;
      1:       f = 659;
      2:       f = 784;
      default: f = 1047;
    endcase
    return CLK_HZ / (2 * f);
  endfunction

  function automatic logic [4:0] model_vec();
    logic aud;
    int   off;
    aud = 1'b0;
    if (m_act == 0) return 5'b0;
    if (m_t < n_notes(m_act) * SLOT) begin
      off = m_t % SLOT;
      if (off < NOTE) aud = ((off / half_of(m_act, m_t / SLOT)) % 2) == 1;
    end
    return {1'b1, 1'b1, 2'(m_act), aud};
  endfunction

  function automatic int highest(input logic [3:1] mask);
    for (int b = 1; b <= 3; b++) if (mask[b]) return b;
    return 0;
  endfunction

  task automatic start_from(input logic [3:1] mask);
    m_act = highest(mask);
    m_t   = 0;
    if (QUEUE && m_act != 0) m_pend[m_act] = 1'b0;
  endtask

  task automatic model_advance(input logic r, input logic [3:1] in);
    logic [3:1] ev;
    ev     = in ^ m_prev;
    m_prev = in;
    if (r) begin
      m_act  = 0;
      m_t    = 0;
      m_pend = '0;
    end else if (m_act != 0) begin
      if (QUEUE) m_pend |= ev;
      if (m_t == n_notes(m_act) * SLOT) begin
        m_act = 0;
        if (QUEUE) start_from(m_pend);
      end else begin
        m_t++;
      end
    end else if (QUEUE) begin
      m_pend |= ev;
      start_from(m_pend);
    end else begin
      start_from(ev);
    end
  endtask

  task automatic step(input logic r, input logic [3:1] in);
    check("cycle", {busy, audio_sd, chime_id, audio_out}, model_vec());
    if (busy) begin
      run++;
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    rst = r;
    {signal_sound_3, signal_sound_2, signal_sound_1} = in;
    model_advance(r, in);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, cur);
  endtask

  initial begin
    rst = 1'b1;
    cur = 3'b101;
    {signal_sound_3, signal_sound_2, signal_sound_1} = cur;
    m_prev = cur;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {audio_out, audio_sd, busy, chime_id}, 5'b0);

    idle(100);
    check("no_event_on_release", last_run, 0);

    cur[3] = ~cur[3];
    step(1'b0, cur);
    check("c3_busy_next", busy, 1);
    check("c3_id", chime_id, 3);
    idle(2600);
    check("c3_len", last_run, 2 * SLOT + 1);

    cur[1] = ~cur[1];
    cur[2] = ~cur[2];
    step(1'b0, cur);
    check("c12_id", chime_id, 1);
    idle(8600);
    check("c12_len", last_run, QUEUE ? 4 * SLOT + 1 + 3 * SLOT + 1 : 4 * SLOT + 1);

    cur[1] = ~cur[1];
    step(1'b0, cur);
    idle(500);
    cur[2] = ~cur[2];
    step(1'b0, cur);
    check("c1_not_preempted", chime_id, 1);
    idle(8600);
    check("c1_then_c2_len", last_run, QUEUE ? 4 * SLOT + 1 + 3 * SLOT + 1 : 4 * SLOT + 1);

    cur[2] = ~cur[2];
    step(1'b0, cur);
    idle(300);
    cur[3] = ~cur[3];
    step(1'b1, cur);
    check("rst_mid_busy", {audio_out, busy, chime_id}, 4'b0);
    idle(300);
    check("rst_no_replay", busy, 0);

    cur[1] = ~cur[1];
    step(1'b0, cur);
    idle(10);
    cur[1] = ~cur[1];
    step(1'b0, cur);
    idle(9800);
    check("c1_twice_len", last_run, QUEUE ? 2 * (4 * SLOT + 1) : 4 * SLOT + 1);

    for (int i = 0; i < 40000; i++) begin
      logic r;
      for (int b = 1; b <= 3; b++) if ($urandom_range(1499) == 0) cur[b] = ~cur[b];
      r = ($urandom_range(19999) == 0);
      step(r, cur);
    end
    idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
